stage3_fast_nn_decoder: RTL
===========================

// Module: stage3_fast_nn_decoder
// PURPOSE
//  Receive side of the stage-3 FAST NN compressor: byte-serial decoder that rebuilds full NN records.
//  Input frame: 16-bit presence map (pmap), optional PID1/MC1/MT1 bytes, then the 8-byte EBSN4..RBSN4 payload.
//  Fields marked "copy" in the pmap are restored from a dictionary that mirrors the encoder's field registers.
//  Sits after the link byte deframer; outputs feed the stage-3 message reassembly.
// PARAMETERS
//  PID_W      8   PID1 width (`field_PID1_bits)
//  MC_W       8   MC1 width (`field_MC1_bits)
//  MT_W       8   MT1 width (`field_MT1_bits)
//  NN_BYTES   8   payload bytes, EBSN4..RBSN4 (64 bits)
//  DICT_INIT  0   reset/clear value of every dictionary entry
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      async active-low reset
//  in_data     in   8      frame byte
//  in_valid    in   1      in_data valid
//  in_sop      in   1      first byte of frame (pmap high byte)
//  in_eop      in   1      last byte of frame
//  in_ready    out  1      decoder accepts byte (transfer = in_valid & in_ready)
//  dict_clr    in   1      block boundary: reset dictionary to DICT_INIT
//  out_pid     out  PID_W  decoded PID1
//  out_mc      out  MC_W   decoded MC1
//  out_mt      out  MT_W   decoded MT1
//  out_nn      out  64     EBSN4..RBSN4 payload, first byte at [63:56]
//  out_len     out  8      consumed frame length in bytes (10..13)
//  out_valid   out  1      record valid; held until out_ready
//  out_ready   in   1      downstream accepts record
//  err         out  1      one-cycle pulse per dropped frame
// BEHAVIOUR
//  - Reset: all outputs 0, in_ready 0 during reset and 1 after it; state IDLE; dictionary = DICT_INIT.
//  - pmap bit 15 is the stop bit and must be 1. Bits 14/13/12 = copy flags for PID/MC/MT (1 = copy, 0 = byte present).
//    Bits 11..0 must be 0. Any violation -> error.
//  - Present fields follow the pmap in order PID, MC, MT. Payload follows them.
//    Frame length = 10 + number of zero copy bits.
//  - States: IDLE -> PM_LO -> {PID,MC,MT skipped when copied} -> PAYLOAD (8-byte counter) -> HOLD -> IDLE. Also DRAIN.
//  - IDLE consumes only bytes with in_sop set. Bytes without in_sop are discarded silently.
//  - Commit happens on the last payload byte:
//    - decoded fields are registered to the outputs;
//    - the dictionary is updated with the present fields only;
//    - the next state is HOLD with out_valid=1.
//    Latency: out_valid rises 1 cycle after the last byte is transferred.
//  - HOLD: in_ready=0 and outputs stable. On out_valid & out_ready, the next state is IDLE and in_ready=1 next cycle.
//  - in_sop arriving outside IDLE/HOLD:
//    - the current frame is aborted and err pulses;
//    - the dictionary is untouched;
//    - the byte is taken as a new pmap high byte.
//  - Error in pmap: err pulses and the next state is DRAIN. DRAIN discards bytes until in_eop, then goes to IDLE.
//    Errored frames never touch the dictionary.
//  - dict_clr applies whenever asserted. It takes effect the cycle after assertion.
//    It wins over a same-cycle commit: the record still outputs, the dictionary still clears.
//  - Out-of-sequence in_eop (no length check): ignored outside DRAIN.
// CONFIGURATION
//  FAST_NN_LEN_CHECK_EN defined:
//    - in_eop must coincide with byte number out_len.
//    - Early in_eop: err, no commit, go to IDLE.
//    - Missing in_eop on the last byte: err, no commit, go to DRAIN.
//  FAST_NN_LEN_CHECK_EN undefined:
//    - framing is by pmap alone; in_eop is used only in DRAIN.
// STRUCTURE
//  - Shared defines in para_def.v:
//    - pmap bit positions, FAST_NN_BASE_LEN=10, state encodings;
//    - field widths reused from `field_*_bits.
//  - Sub-module fast_nn_dict holds PID/MC/MT registers. Its inputs are clr, per-field commit enables and commit data.
//    Field outputs: q_pid/q_mc/q_mt.
// TESTING
//  - Full copy: after reset, dict_clr, bytes F0 00 + 8 payload 01..08.
//    -> pid=mc=mt=0, nn=0x0102030405060708, out_len=10, err=0.
//  - All present: B0.. pmap 80 00, then 11 22 33 + payload.
//    -> pid=11 mc=22 mt=33 len=13; next frame F0 00 + payload -> pid=11 mc=22 mt=33 len=10.
//  - Backpressure: out_ready=0 for 5 cycles -> out_valid and out fields stable, in_ready=0. Release -> in_ready=1 next cycle.
//  - Bad pmap 70 00 (stop bit 0) with eop on byte 10.
//    -> one err pulse, no out_valid, dictionary unchanged, next good frame decodes.
//  - New in_sop mid-payload -> err pulse, the new frame decodes correctly.
//    With FAST_NN_LEN_CHECK_EN: eop on byte 9 of a len-10 frame -> err, no commit.
//  - rst_n low mid-PAYLOAD -> outputs 0 immediately.
//    Then dict_clr asserted in the commit cycle -> record output, following copy-frame yields DICT_INIT.

Source files
------------

// File: rtl/stage3_fast_nn_decoder_pkg.sv
// Shared definitions for the stage-3 FAST NN decoder: pmap layout, base frame length,
// FSM states and small decode helpers.
package stage3_fast_nn_decoder_pkg;

    localparam int unsigned FAST_NN_BASE_LEN = 10;

    localparam int unsigned PMAP_STOP_BIT = 15;
    localparam int unsigned PMAP_PID_BIT  = 14;
    localparam int unsigned PMAP_MC_BIT   = 13;
    localparam int unsigned PMAP_MT_BIT   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PM_LO,
        S_PID,
        S_MC,
        S_MT,
        S_PAYLOAD,
        S_HOLD,
        S_DRAIN
    } state_t;

    function automatic logic pmap_ok(input logic [15:0] pmap);
        return pmap[PMAP_STOP_BIT] && (pmap[11:0] == '0);
    endfunction

    // copy = {pid, mc, mt} copy flags; each present field adds one byte
    function automatic logic [7:0] frame_len(input logic [2:0] copy);
        return 8'(FAST_NN_BASE_LEN) + {7'd0, ~copy[2]} + {7'd0, ~copy[1]} + {7'd0, ~copy[0]};
    endfunction

    function automatic state_t next_field(input state_t cur, input logic [2:0] copy);
        state_t nxt;
        nxt = S_PAYLOAD;
        if (cur == S_PM_LO && !copy[2])
            nxt = S_PID;
        else if ((cur inside {S_PM_LO, S_PID}) && !copy[1])
            nxt = S_MC;
        else if ((cur inside {S_PM_LO, S_PID, S_MC}) && !copy[0])
            nxt = S_MT;
        return nxt;
    endfunction

endpackage

// File: rtl/stage3_fast_nn_decoder_dict.sv
// Field dictionary mirroring the encoder's PID/MC/MT registers; clear wins over commit.
module fast_nn_dict #(
    parameter int unsigned PID_W     = 8,
    parameter int unsigned MC_W      = 8,
    parameter int unsigned MT_W      = 8,
    parameter int unsigned DICT_INIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en_pid,
    input  logic             en_mc,
    input  logic             en_mt,
    input  logic [PID_W-1:0] d_pid,
    input  logic [MC_W-1:0]  d_mc,
    input  logic [MT_W-1:0]  d_mt,
    output logic [PID_W-1:0] q_pid,
    output logic [MC_W-1:0]  q_mc,
    output logic [MT_W-1:0]  q_mt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pid <= PID_W'(DICT_INIT);
            q_mc  <= MC_W'(DICT_INIT);
            q_mt  <= MT_W'(DICT_INIT);
        end else if (clr) begin
            q_pid <= PID_W'(DICT_INIT);
            q_mc  <= MC_W'(DICT_INIT);
            q_mt  <= MT_W'(DICT_INIT);
        end else begin
            if (en_pid) q_pid <= d_pid;
            if (en_mc)  q_mc  <= d_mc;
            if (en_mt)  q_mt  <= d_mt;
        end
    end

endmodule

// File: rtl/stage3_fast_nn_decoder.sv
// Byte-serial stage-3 FAST NN decoder: parses pmap, optional PID/MC/MT and the 8-byte payload.
// Define FAST_NN_LEN_CHECK_EN to enforce in_eop on the last byte of every frame.
module stage3_fast_nn_decoder
    import stage3_fast_nn_decoder_pkg::*;
#(
    parameter int unsigned PID_W     = 8,
    parameter int unsigned MC_W      = 8,
    parameter int unsigned MT_W      = 8,
    parameter int unsigned NN_BYTES  = 8,
    parameter int unsigned DICT_INIT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    input  logic                  dict_clr,
    output logic [PID_W-1:0]      out_pid,
    output logic [MC_W-1:0]       out_mc,
    output logic [MT_W-1:0]       out_mt,
    output logic [NN_BYTES*8-1:0] out_nn,
    output logic [7:0]            out_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    localparam int unsigned CNT_W = $clog2(NN_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NN_BYTES - 1);

    state_t                  state_q, state_d;
    logic                    alive_q;
    logic [7:0]              pm_hi_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PID_W-1:0]        pid_q;
    logic [MC_W-1:0]         mc_q;
    logic [MT_W-1:0]         mt_q;
    logic [NN_BYTES*8-1:0]   nn_sr_q;
    logic [PID_W-1:0]        q_pid;
    logic [MC_W-1:0]         q_mc;
    logic [MT_W-1:0]         q_mt;
    logic [2:0]              copy;

    logic xfer, in_frame, take_sop, abort, pm_bad, last_raw;
    logic early_eop, missing_eop, commit, err_set;

    assign copy = {pm_hi_q[PMAP_PID_BIT-8], pm_hi_q[PMAP_MC_BIT-8], pm_hi_q[PMAP_MT_BIT-8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        in_ready    = alive_q && (state_q != S_HOLD);
        out_valid   = (state_q == S_HOLD);
        xfer        = in_valid && in_ready;
        in_frame    = state_q inside {S_PM_LO, S_PID, S_MC, S_MT, S_PAYLOAD};
        // DRAIN also restarts on in_sop, but its frame was already reported
        take_sop    = xfer && in_sop && (in_frame || state_q == S_IDLE || state_q == S_DRAIN);
        abort       = xfer && in_sop && in_frame;
        pm_bad      = xfer && !in_sop && (state_q == S_PM_LO) && !pmap_ok({pm_hi_q, in_data});
        last_raw    = xfer && !in_sop && (state_q == S_PAYLOAD) && (cnt_q == LAST_CNT);
        early_eop   = 1'b0;
        missing_eop = 1'b0;
`ifdef FAST_NN_LEN_CHECK_EN
        early_eop   = xfer && !in_sop && in_eop && in_frame && !pm_bad && !last_raw;
        missing_eop = last_raw && !in_eop;
        commit      = last_raw && in_eop;
`else
        commit      = last_raw;
`endif
        err_set     = abort || pm_bad || early_eop || missing_eop;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take_sop) state_d = S_PM_LO;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            S_DRAIN: begin
                if (take_sop)             state_d = S_PM_LO;
                else if (xfer && in_eop)  state_d = S_IDLE;
            end
            default: begin
                if (take_sop)             state_d = S_PM_LO;
                else if (pm_bad)          state_d = in_eop ? S_IDLE : S_DRAIN;
                else if (early_eop)       state_d = S_IDLE;
                else if (missing_eop)     state_d = S_DRAIN;
                else if (commit)          state_d = S_HOLD;
                else if (xfer && state_q != S_PAYLOAD)
                    state_d = next_field(state_q, copy);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            err     <= 1'b0;
            pm_hi_q <= '0;
            cnt_q   <= '0;
            pid_q   <= '0;
            mc_q    <= '0;
            mt_q    <= '0;
            nn_sr_q <= '0;
            out_pid <= '0;
            out_mc  <= '0;
            out_mt  <= '0;
            out_nn  <= '0;
            out_len <= '0;
        end else begin
            alive_q <= 1'b1;
            err     <= err_set;
            if (take_sop) begin
                pm_hi_q <= in_data;
                cnt_q   <= '0;
            end else if (xfer) begin
                case (state_q)
                    S_PID:     pid_q <= PID_W'(in_data);
                    S_MC:      mc_q  <= MC_W'(in_data);
                    S_MT:      mt_q  <= MT_W'(in_data);
                    S_PAYLOAD: begin
                        nn_sr_q <= {nn_sr_q[NN_BYTES*8-9:0], in_data};
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                out_pid <= copy[2] ? q_pid : pid_q;
                out_mc  <= copy[1] ? q_mc  : mc_q;
                out_mt  <= copy[0] ? q_mt  : mt_q;
                out_nn  <= {nn_sr_q[NN_BYTES*8-9:0], in_data};
                out_len <= frame_len(copy);
            end
        end
    end

    fast_nn_dict #(
        .PID_W     (PID_W),
        .MC_W      (MC_W),
        .MT_W      (MT_W),
        .DICT_INIT (DICT_INIT)
    ) u_dict (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (dict_clr),
        .en_pid (commit && !copy[2]),
        .en_mc  (commit && !copy[1]),
        .en_mt  (commit && !copy[0]),
        .d_pid  (pid_q),
        .d_mc   (mc_q),
        .d_mt   (mt_q),
        .q_pid  (q_pid),
        .q_mc   (q_mc),
        .q_mt   (q_mt)
    );

endmodule
